// File: rtl/wb_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : wb_bridge_pkg
//  Description : Shared types and constants for the Wishbone slow bridge.
//                - state_e          : bridge FSM state encoding
//                - DEFAULT_ERR_DATA : read data returned when a slot times out
//                - TMO_W            : width of the timeout tick counter
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          TMO_W            = 16;

endpackage : wb_bridge_pkg
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_en_gen
//  Description : Free-running clock-enable generator. Counts 0..DIV-1 and
//                raises tick_o for the single cycle in which the count is
//                DIV-1. Runs continuously, independent of bus activity.
//  Ports       : clk_i  - clock
//                rst_i  - asynchronous active-high reset (count -> 0)
//                tick_o - one-cycle enable, every DIV cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_en_gen #(
    parameter int DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    assign tick   = (cnt_q == CNT_MAX);
    assign cnt_d  = tick ? '0 : cnt_q + 1'b1;
    assign tick_o = tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : clk_en_gen
`default_nettype wire

// File: rtl/wb_slow_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : wb_slow_bridge
//  Description : Wishbone slave stage between the Caravel master and the
//                macro address decoder/mux. A master request is captured,
//                launched downstream on the next divider tick, held until the
//                decoder acks, then answered with a one-cycle ack and the
//                captured read data. Slots that never ack are answered with
//                ERR_DATA after TIMEOUT ticks so the master never stalls.
//  Ports       : wb_clk_i, wb_rst_i         - clock, async active-high reset
//                wbs_cyc/stb/we/sel/adr/dat - master request
//                wbs_ack_o, wbs_dat_o       - master response (registered)
//                d_stb/we/sel/adr/dat_o     - captured request to decoder
//                d_ack_i, d_dat_i           - OR-ed decoder response
//                tmo_o                      - flags a timeout response
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_slow_bridge
    import wb_bridge_pkg::*;
#(
    parameter int          DIV      = 8,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        d_stb_o,
    output logic        d_we_o,
    output logic [3:0]  d_sel_o,
    output logic [31:0] d_adr_o,
    output logic [31:0] d_dat_o,
    input  logic        d_ack_i,
    input  logic [31:0] d_dat_i,
    output logic        tmo_o
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic               d_stb_q, d_stb_d;
    logic               d_we_q,  d_we_d;
    logic [3:0]         d_sel_q, d_sel_d;
    logic [31:0]        d_adr_q, d_adr_d;
    logic [31:0]        d_dat_q, d_dat_d;
    logic               ack_q,   ack_d;
    logic [31:0]        rdat_q,  rdat_d;
    logic               tmo_q,   tmo_d;
    logic [TMO_W-1:0]   tcnt_q,  tcnt_d;

    logic               tick;
    logic [TMO_W-1:0]   tcnt_inc;
    logic               tmo_hit;

    clk_en_gen #(
        .DIV    (DIV)
    ) u_clk_en (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .tick_o (tick)
    );

    // The tick that brings the count to TIMEOUT is the one that fires the
    // error response; the counter never needs to go past TIMEOUT.
    assign tcnt_inc = tcnt_q + 1'b1;
    assign tmo_hit  = (tcnt_inc == TMO_LIMIT);

    always_comb begin
        state_d = state_q;
        d_stb_d = d_stb_q;
        d_we_d  = d_we_q;
        d_sel_d = d_sel_q;
        d_adr_d = d_adr_q;
        d_dat_d = d_dat_q;
        ack_d   = ack_q;
        rdat_d  = rdat_q;
        tmo_d   = tmo_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    d_we_d  = wbs_we_i;
                    d_sel_d = wbs_sel_i;
                    d_adr_d = wbs_adr_i;
                    d_dat_d = wbs_dat_i;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    // Launch only on a tick so downstream sees DIV-aligned strobes.
                    d_stb_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!wbs_cyc_i) begin
                    // Master gave up: withdraw silently, no ack.
                    d_stb_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (d_ack_i) begin
                    // A real ack beats a coincident final timeout tick.
                    rdat_d  = d_we_q ? 32'h0 : d_dat_i;
                    d_stb_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (tick) begin
                    tcnt_d = tcnt_inc;
                    if (tmo_hit) begin
                        rdat_d  = ERR_DATA;
                        tmo_d   = 1'b1;
                        d_stb_d = 1'b0;
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                ack_d   = 1'b0;
                tmo_d   = 1'b0;
                rdat_d  = 32'h0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            d_stb_q <= 1'b0;
            d_we_q  <= 1'b0;
            d_sel_q <= 4'h0;
            d_adr_q <= 32'h0;
            d_dat_q <= 32'h0;
            ack_q   <= 1'b0;
            rdat_q  <= 32'h0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            d_stb_q <= d_stb_d;
            d_we_q  <= d_we_d;
            d_sel_q <= d_sel_d;
            d_adr_q <= d_adr_d;
            d_dat_q <= d_dat_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign tmo_o     = tmo_q;
    assign d_stb_o   = d_stb_q;
    assign d_we_o    = d_we_q;
    assign d_sel_o   = d_sel_q;
    assign d_adr_o   = d_adr_q;
    assign d_dat_o   = d_dat_q;

endmodule : wb_slow_bridge
`default_nettype wire
